// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with full/empty/almost flags and a registered
//            read port. Define SYNC_FIFO_OUTPUT_REG_EN for an extra output stage.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH_WIDTH      = 10,
    parameter int DATA_WIDTH       = 12,
    parameter int ALMOST_FULL_NUM  = 1020,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  wr_full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_empty,
    output logic                  almost_empty
);

    localparam logic [DEPTH_WIDTH:0] c_ptr_one      = (DEPTH_WIDTH+1)'(1);
    localparam logic [DEPTH_WIDTH:0] c_almost_full  = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
    localparam logic [DEPTH_WIDTH:0] c_almost_empty = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

    logic [DATA_WIDTH-1:0]  r_mem [0:(1<<DEPTH_WIDTH)-1];
    logic [DEPTH_WIDTH:0]   r_wr_ptr;
    logic [DEPTH_WIDTH:0]   r_rd_ptr;
    logic [DATA_WIDTH-1:0]  r_rd_data;
    logic [DEPTH_WIDTH:0]   w_count;
    logic                   w_wr_accept;
    logic                   w_rd_accept;

    // Acceptance is gated by flags from the registered pointers only
    assign w_wr_accept = wr_en && !wr_full;
    assign w_rd_accept = rd_en && !rd_empty;

    assign w_count      = r_wr_ptr - r_rd_ptr;
    assign wr_full      = (r_wr_ptr[DEPTH_WIDTH] != r_rd_ptr[DEPTH_WIDTH]) &&
                          (r_wr_ptr[DEPTH_WIDTH-1:0] == r_rd_ptr[DEPTH_WIDTH-1:0]);
    assign rd_empty     = (r_wr_ptr == r_rd_ptr);
    assign almost_full  = (w_count >= c_almost_full);
    assign almost_empty = (w_count <= c_almost_empty);

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr[DEPTH_WIDTH-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_accept) begin
                r_rd_ptr  <= r_rd_ptr + c_ptr_one;
                r_rd_data <= r_mem[r_rd_ptr[DEPTH_WIDTH-1:0]];
            end
        end
    end

`ifdef SYNC_FIFO_OUTPUT_REG_EN
    logic [DATA_WIDTH-1:0] r_rd_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data_q <= '0;
        end else begin
            r_rd_data_q <= r_rd_data;
        end
    end

    assign rd_data = r_rd_data_q;
`else
    assign rd_data = r_rd_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo
// Brief    : Self-checking bench for sync_fifo: vector table plus queue scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

    localparam int c_dw    = 12;
    localparam int c_depth = 1024;

    logic            clk;
    logic            rst_n;
    logic [c_dw-1:0] wr_data;
    logic            wr_en;
    logic            wr_full;
    logic            almost_full;
    logic            rd_en;
    logic [c_dw-1:0] rd_data;
    logic            rd_empty;
    logic            almost_empty;

    sync_fifo #(
        .DEPTH_WIDTH     (10),
        .DATA_WIDTH      (c_dw),
        .ALMOST_FULL_NUM (1020),
        .ALMOST_EMPTY_NUM(4)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .wr_full     (wr_full),
        .almost_full (almost_full),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_empty    (rd_empty),
        .almost_empty(almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            we;
        logic [c_dw-1:0] wd;
        logic            re;
        logic            empty;
        logic            ae;
        logic            full;
        logic            af;
        logic [c_dw-1:0] rd;
    } vec_t;

    vec_t            vecs [16];
    logic [c_dw-1:0] sb [$];
    logic [c_dw-1:0] m_rd;
    logic [c_dw-1:0] m_rd_q;
    int              n_checks;
    int              n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_flags(input int cnt);
        check("rd_empty", 32'(rd_empty), 32'(cnt == 0));
        check("wr_full", 32'(wr_full), 32'(cnt == c_depth));
        check("almost_empty", 32'(almost_empty), 32'(cnt <= 4));
        check("almost_full", 32'(almost_full), 32'(cnt >= 1020));
    endtask

    // One clock with model update; sampled 1 ns after the rising edge
    task automatic cycle(input logic we, input logic [c_dw-1:0] wd, input logic re);
        bit wacc, racc;
        wr_en = we; wr_data = wd; rd_en = re;
        wacc = we && (sb.size() != c_depth);
        racc = re && (sb.size() != 0);
        @(posedge clk); #1;
        m_rd_q = m_rd;
        if (racc) m_rd = sb.pop_front();
        if (wacc) sb.push_back(wd);
`ifdef SYNC_FIFO_OUTPUT_REG_EN
        check("rd_data", 32'(rd_data), 32'(m_rd_q));
`else
        check("rd_data", 32'(rd_data), 32'(m_rd));
`endif
        check_flags(sb.size());
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic model_reset();
        sb.delete();
        m_rd   = '0;
        m_rd_q = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_pass = 0;
        wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        model_reset();

        //                we  wd      re   emp ae  full af  rd
        vecs[0]  = '{1'b1, 12'h111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000};
        vecs[1]  = '{1'b1, 12'h222, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000};
        vecs[2]  = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h111};
        vecs[3]  = '{1'b1, 12'h333, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h222};
        vecs[4]  = '{1'b1, 12'h444, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h333};
        vecs[5]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h444};
        vecs[6]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h444};
        vecs[7]  = '{1'b1, 12'h555, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h444};
        vecs[8]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h555};
        vecs[9]  = '{1'b1, 12'h601, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h555};
        vecs[10] = '{1'b1, 12'h602, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h555};
        vecs[11] = '{1'b1, 12'h603, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h555};
        vecs[12] = '{1'b1, 12'h604, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h555};
        vecs[13] = '{1'b1, 12'h605, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h555};
        vecs[14] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h601};
        vecs[15] = '{1'b1, 12'h606, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h601};

        // Reset held for 200 ns
        rst_n = 1'b0;
        #200;
        check("rst_rd_empty", 32'(rd_empty), 32'd1);
        check("rst_almost_empty", 32'(almost_empty), 32'd1);
        check("rst_wr_full", 32'(wr_full), 32'd0);
        check("rst_almost_full", 32'(almost_full), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_flags(0);
        check("post_rst_rd_data", 32'(rd_data), 32'd0);

        // Vector table
        for (int i = 0; i < 16; i++) begin
            wr_en = vecs[i].we; wr_data = vecs[i].wd; rd_en = vecs[i].re;
            @(posedge clk); #1;
            check($sformatf("vec%0d_empty", i), 32'(rd_empty), 32'(vecs[i].empty));
            check($sformatf("vec%0d_ae", i), 32'(almost_empty), 32'(vecs[i].ae));
            check($sformatf("vec%0d_full", i), 32'(wr_full), 32'(vecs[i].full));
            check($sformatf("vec%0d_af", i), 32'(almost_full), 32'(vecs[i].af));
`ifdef SYNC_FIFO_OUTPUT_REG_EN
            check($sformatf("vec%0d_rd", i), 32'(rd_data), (i == 0) ? 32'd0 : 32'(vecs[i-1].rd));
`else
            check($sformatf("vec%0d_rd", i), 32'(rd_data), 32'(vecs[i].rd));
`endif
        end
        wr_en = 1'b0; rd_en = 1'b0;

        // Fill past capacity with data counting down from 0xFFF
        do_reset();
        for (int i = 0; i < 1025; i++) begin
            cycle(1'b1, 12'hFFF - 12'(i), 1'b0);
            if (i == 0)    check("fill_first_not_empty", 32'(rd_empty), 32'd0);
            if (i == 1018) check("fill_1019_not_af", 32'(almost_full), 32'd0);
            if (i == 1019) check("fill_1020_af", 32'(almost_full), 32'd1);
            if (i == 1022) check("fill_1023_not_full", 32'(wr_full), 32'd0);
            if (i == 1023) check("fill_1024_full", 32'(wr_full), 32'd1);
        end

        // Drain past empty; the dropped 0xBFF must never appear
        for (int i = 0; i < 1025; i++) begin
            cycle(1'b0, '0, 1'b1);
            if (i == 1019) check("drain_4_left_ae", 32'(almost_empty), 32'd1);
            if (i == 1022) check("drain_1023_not_empty", 32'(rd_empty), 32'd0);
            if (i == 1023) check("drain_1024_empty", 32'(rd_empty), 32'd1);
        end
        check("drain_extra_hold", 32'(rd_data), 32'hC00);

        // Simultaneous traffic at 512 words, then at full
        for (int i = 0; i < 512; i++) cycle(1'b1, 12'(i), 1'b0);
        for (int i = 0; i < 100; i++) cycle(1'b1, 12'(12'h800 + i), 1'b1);
        for (int i = 0; i < 512; i++) cycle(1'b1, 12'(12'h400 + i), 1'b0);
        check("sim_full_before", 32'(wr_full), 32'd1);
        cycle(1'b1, 12'hABC, 1'b1);
        check("sim_full_write_rejected", 32'(wr_full), 32'd0);
        for (int i = 0; i < 1023; i++) cycle(1'b0, '0, 1'b1);
        check("sim_full_drained", 32'(rd_empty), 32'd1);

        // Streaming wrap-around, alternating fill-to-full and drain-to-empty
        do_reset();
        begin
            int written = 0;
            int budget  = 0;
            bit filling = 1'b1;
            while (written < 3000 && budget < 20000) begin
                bit we, re;
                if (filling) begin we = 1'b1; re = ($urandom_range(3) == 0); end
                else         begin re = 1'b1; we = ($urandom_range(3) == 0); end
                if (we && sb.size() != c_depth) written++;
                cycle(we, 12'(written * 7 + 3), re);
                if (filling && sb.size() == c_depth) filling = 1'b0;
                if (!filling && sb.size() == 0)      filling = 1'b1;
                budget++;
            end
            check("wrap_budget", 32'(budget < 20000), 32'd1);
        end
        while (sb.size() != 0) cycle(1'b0, '0, 1'b1);

        // Reset with 300 words stored
        for (int i = 0; i < 300; i++) cycle(1'b1, 12'(12'h300 + i), 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_rd_empty", 32'(rd_empty), 32'd1);
        check("midrst_wr_full", 32'(wr_full), 32'd0);
        check("midrst_rd_data", 32'(rd_data), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 12'h5A5, 1'b0);
        cycle(1'b1, 12'h0F0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo.md
# sync_fifo

Single-clock first-in/first-out buffer with full, empty, almost-full and almost-empty flags. It decouples a producer and a consumer that share one clock domain. It sits between a data source and its sink, where the source can burst up to 2**DEPTH_WIDTH words ahead of the sink.

## Interface
- DEPTH_WIDTH, 10: log2 of storage depth; capacity = 2**DEPTH_WIDTH words (1024).
- DATA_WIDTH, 12: width of wr_data and rd_data.
- ALMOST_FULL_NUM, 1020: almost_full threshold, in stored words.
- ALMOST_EMPTY_NUM, 4: almost_empty threshold, in stored words.

One clock; reset is asynchronous and active-low.

- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset; asserts immediately, releases on the next clock edge.
- wr_data  in  DATA_WIDTH  write data.
- wr_en  in  1  write request.
- wr_full  out  1  FIFO holds 2**DEPTH_WIDTH words.
- almost_full  out  1  stored count >= ALMOST_FULL_NUM.
- rd_en  in  1  read request.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_empty  out  1  FIFO holds 0 words.
- almost_empty  out  1  stored count <= ALMOST_EMPTY_NUM.

## Operation
- Storage: 2**DEPTH_WIDTH x DATA_WIDTH memory array.
- Pointers: write and read pointers are DEPTH_WIDTH+1 bits wide; the extra MSB is the wrap bit.
- Count: count = wr_ptr - rd_ptr, modulo 2**(DEPTH_WIDTH+1).
  - full when MSBs differ and lower bits are equal.
  - empty when the pointers are equal.
- Write accept: wr_en && !wr_full. Stores wr_data at wr_ptr and increments wr_ptr.
- Write while full: ignored, with no change to memory, pointers or flags.
- Read accept: rd_en && !rd_empty. Loads mem[rd_ptr] into rd_data and increments rd_ptr.
- Read while empty: ignored; rd_data holds its last value.
- Simultaneous accepted read and write: both performed, count unchanged.
- Flag gating uses the flags as they stand before the edge:
  - a write to a full FIFO is rejected even if a read occurs in the same cycle;
  - a read from an empty FIFO is rejected even if a write occurs in the same cycle.
- Pointer wrap: natural modulo wrap of DEPTH_WIDTH+1-bit counters; ordering is preserved across wrap.
- Flags are derived from the registered pointers only, never from the current inputs.

## Timing
- Reset values:
  - wr_ptr = rd_ptr = 0
  - rd_data = 0
  - rd_empty = 1, almost_empty = 1
  - wr_full = 0, almost_full = 0
  - memory contents are not reset.
- Reset mid-operation discards all stored words. Outputs take their reset values asynchronously.
- Read latency: 1 cycle. With rd_en sampled high at edge N on a non-empty FIFO, rd_data is valid after edge N and stays valid until the next accepted read.
- Back-to-back reads give one new word per cycle.
- Flags update in the same edge that changes the pointers:
  - wr_full rises after the edge that accepts word number 2**DEPTH_WIDTH;
  - rd_empty rises after the edge that accepts the last read.
- Write-to-read: a word written at edge N can first be read by an rd_en sampled at edge N+1.

## Configuration
- Macro SYNC_FIFO_OUTPUT_REG_EN.
- Defined: adds one output register stage after the memory read. Read latency becomes 2 cycles, and the extra register also resets to 0. Flags are unaffected.
- Undefined: read latency is 1 cycle, as specified in Timing.

## Test plan
- Reset check: hold rst_n low for 200 ns, then release. Required: rd_empty=1, almost_empty=1, wr_full=0, almost_full=0, rd_data=0.
- Fill past capacity:
  - stimulus: wr_en high for 1025 consecutive cycles with wr_data counting down from 0xFFF;
  - required: almost_full asserts after the 1020th write;
  - required: wr_full asserts after the 1024th write (0xC00);
  - required: the 1025th word (0xBFF) is dropped;
  - required: rd_empty deasserts after the first write.
- Drain past empty:
  - stimulus: rd_en high for 1025 consecutive cycles;
  - required: rd_data is 0xFFF, 0xFFE, … 0xC00, each one cycle after its rd_en;
  - required: almost_empty asserts when 4 words remain; rd_empty asserts after the 1024th read;
  - required: the extra read leaves rd_data at 0xC00.
- Simultaneous read and write:
  - at 512 words, with wr_en and rd_en both high for 100 cycles: count stays 512, data order is preserved, flags are unchanged;
  - at full, the write is rejected and the read is accepted, leaving 1023 words.
- Wrap-around: write and read 3000 words in a streaming pattern. Required: no data mismatch across pointer wrap, and wr_full/rd_empty are correct at each boundary.
- Reset mid-operation: with 300 words stored, pulse rst_n low. Required: rd_empty=1 immediately; the next written word is the first one read back.
